// File: rtl/half_adder.sv
// Half adder cell: 1-bit sum and carry of two input bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Pure combinational sum/carry.
  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus a carry-in,
// one bit per cycle, using two half_adder cells as a 1-bit full adder.
//
// Handshake: start is accepted only on a rising clock edge where ready=1
// (IDLE). While busy=1 (RUN) or done=1 (DONE) start is ignored, so nothing is
// queued. done is a one-cycle pulse; sum/cout are valid during that cycle and
// stay held until the next completion or reset.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter needs at least one bit even when WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] opa, opb, acc, acc_next;
  logic             carry, carry_next;
  logic [CW-1:0]    cnt;
  logic             s1, c1, s2, c2;
  logic             last_bit;

  // Full adder built from the two existing half-adder cells.
  half_adder u_ha1 (.a(opa[0]), .b(opb[0]), .sum(s1), .carry(c1));
  half_adder u_ha2 (.a(s1),     .b(carry),  .sum(s2), .carry(c2));

  // Carry chain and result shifter input for the current bit.
  always_comb begin
    carry_next          = c1 | c2;
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = s2;
  end

  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start)    state_n = ST_RUN;
      ST_RUN:  if (last_bit) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from state so they are mutually exclusive.
  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_next;
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          // Results are published on the edge that enters DONE.
          if (last_bit) begin
            sum  <= acc_next;
            cout <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 builds side by side.
module tb_serial_add_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=8 instance signals
  logic       start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance signals
  logic       start1, cin1, ready1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] held_sum8;
  logic       held_cout8;
  logic [0:0] held_sum1;
  logic       held_cout1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready8(input string tag);
    int n;
    n = 0;
    while (!ready8 && n < 30) begin
      step();
      n++;
    end
    if (!ready8) check({tag, " ready_timeout"}, ready8, 1);
  endtask

  // One WIDTH=8 operation; optionally pulses start (a=1,b=1) mid-RUN.
  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                     input bit mid_start, input string tag);
    logic [8:0] e;
    int lat, extra;
    bit stable_ok;
    e = {1'b0, va} + {1'b0, vb} + {8'b0, vc};
    wait_ready8(tag);
    a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check({tag, " busy"}, busy8, 1);
    check({tag, " not_ready"}, ready8, 0);
    lat = 0;
    stable_ok = 1'b1;
    while (!done8 && lat < 20) begin
      step();
      lat++;
      if (mid_start && lat == 3) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
      if (!done8 && (sum8 !== held_sum8 || cout8 !== held_cout8)) stable_ok = 1'b0;
    end
    start8 = 1'b0;
    check({tag, " latency"}, lat, 8);
    check({tag, " sum"}, sum8, e[7:0]);
    check({tag, " cout"}, cout8, e[8]);
    check({tag, " held_during_run"}, stable_ok, 1);
    held_sum8 = e[7:0];
    held_cout8 = e[8];
    step();
    check({tag, " ready_after"}, ready8, 1);
    check({tag, " done_pulse"}, done8, 0);
    if (mid_start) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (done8) extra++;
        step();
      end
      check({tag, " extra_done"}, extra, 0);
      check({tag, " sum_after_ignored_start"}, sum8, e[7:0]);
    end
  endtask

  // One WIDTH=1 operation.
  task automatic op1(input logic va, input logic vb, input logic vc, input string tag);
    logic [1:0] e;
    int lat;
    e = {1'b0, va} + {1'b0, vb} + {1'b0, vc};
    a1 = va; b1 = vb; cin1 = vc; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check({tag, " busy"}, busy1, 1);
    lat = 0;
    while (!done1 && lat < 10) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, 1);
    check({tag, " sum"}, sum1, e[0]);
    check({tag, " cout"}, cout1, e[1]);
    held_sum1 = e[0];
    held_cout1 = e[1];
    step();
    check({tag, " ready_after"}, ready1, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, last, nd, quiet_done;
    bit stab;
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic rc;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    held_sum8 = '0; held_cout8 = 1'b0; held_sum1 = '0; held_cout1 = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst ready8", ready8, 1);
    check("rst busy8", busy8, 0);
    check("rst done8", done8, 0);
    check("rst sum8", sum8, 0);
    check("rst cout8", cout8, 0);
    check("rst ready1", ready1, 1);
    check("rst sum1", sum1, 0);

    // directed WIDTH=8 vectors
    op8(8'd3,   8'd5,   1'b0, 1'b0, "add_3_5");
    op8(8'hFF,  8'h01,  1'b0, 1'b0, "add_ff_01");
    op8(8'hFF,  8'hFF,  1'b1, 1'b0, "add_ff_ff_c");
    op8(8'h21,  8'h42,  1'b1, 1'b1, "mid_start");

    // reset during the 4th RUN cycle aborts the operation
    wait_ready8("abort");
    a8 = 8'd50; b8 = 8'd60; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort ready", ready8, 1);
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort sum", sum8, 0);
    check("abort cout", cout8, 0);
    held_sum8 = '0; held_cout8 = 1'b0;
    held_sum1 = '0; held_cout1 = 1'b0;
    quiet_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) quiet_done++;
    end
    check("abort no_done", quiet_done, 0);
    op8(8'd7, 8'd9, 1'b0, 1'b0, "after_abort");

    // back-to-back with start held high
    wait_ready8("b2b");
    exp_q.push_back(9'd30);
    exp_q.push_back(9'd301);
    exp_q.push_back(9'd510);
    a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
    cyc = 0; last = 0; nd = 0; stab = 1'b1;
    while (nd < 3 && cyc < 60) begin
      step();
      cyc++;
      if (done8) begin
        e = exp_q.pop_front();
        check("b2b sum", sum8, e[7:0]);
        check("b2b cout", cout8, e[8]);
        if (nd == 0) check("b2b first_latency", cyc, 9);
        else         check("b2b interval", cyc - last, 10);
        last = cyc;
        nd++;
        held_sum8 = e[7:0];
        held_cout8 = e[8];
        if (nd == 1) begin a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1; end
        if (nd == 2) begin a8 = 8'd255; b8 = 8'd255; cin8 = 1'b0; end
        if (nd == 3) start8 = 1'b0;
      end else if (sum8 !== held_sum8 || cout8 !== held_cout8) begin
        stab = 1'b0;
      end
    end
    start8 = 1'b0;
    check("b2b done_count", nd, 3);
    check("b2b held_between", stab, 1);

    // WIDTH=1 build: directed then exhaustive
    op1(1'b1, 1'b1, 1'b1, "w1_111");
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], $sformatf("w1_%0d", i));
    end

    // random vectors on WIDTH=8
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      op8(ra, rb, rc, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
